ebus_diag_master: RTL and testbench
===================================

# ebus_diag_master

Initiator side of the EBOX diagnostic bus: it issues diagnostic function cycles on EBUS (function code on `ds`, `diagStrobe` pulse, data driven or sampled) on behalf of the front-end/console. It accepts one request at a time from a simple valid/ready host port. It sequences the setup, strobe and hold phases that the EBOX modules decode (load functions 00x–07x, read functions 10x–17x). It returns a completion, carrying the captured EBUS word for reads.

## Interface
Parameters:
- `SETUP_CYC`, default 2: cycles `ds`/data are stable before the strobe; legal range 1–15.
- `STROBE_CYC`, default 2: cycles `diagStrobe` is asserted; legal range 1–15.
- `HOLD_CYC`, default 1: cycles `ds`/data are held after the strobe drops; legal range 1–15.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: sole clock, all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces idle.
- `req_valid` in 1: host request present.
- `req_ready` out 1: block can accept a request.
- `req_func` in 7 [0:6]: diagnostic function code; bit 0 = 1 means a read function.
- `req_data` in 36 [0:35]: write data for load functions.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 36 [0:35]: captured EBUS data for reads; zero for loads.
- `busy` out 1: a cycle is in progress, i.e. state is not IDLE.
- `ebus_ds` out 7 [0:6]: function select driven to EBUS `ds`.
- `ebus_diag_strobe` out 1: EBUS `diagStrobe`.
- `ebus_data_out` out 36 [0:35]: data driven onto EBUS.
- `ebus_data_drive` out 1: enables `ebus_data_out` onto EBUS.
- `ebus_data_in` in 36 [0:35]: EBUS data as seen on the bus.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP. A 4-bit phase counter counts down in SETUP, STROBE and HOLD.
- **IDLE**
  - Behaviour: `req_ready`=1; `ebus_ds`=0, so `ds[0:1]`=0 and the EBOX stays in microcode control.
  - Handshake: accept on `req_valid & req_ready`. On accept, latch `req_func` into `func_q` and `req_data` into `data_q`, and set `is_read` = `req_func[0]`.
  - Transition: go to SETUP with the counter = `SETUP_CYC`-1.
- **SETUP**
  - `ebus_ds`=`func_q`.
  - For loads (`is_read`=0): `ebus_data_drive`=1 and `ebus_data_out`=`data_q`.
  - For reads: `ebus_data_drive`=0.
  - When the counter reaches 0, go to STROBE with the counter = `STROBE_CYC`-1.
- **STROBE**
  - Same drives as SETUP, plus `ebus_diag_strobe`=1.
  - On the final STROBE cycle (counter=0), reads register `ebus_data_in` into `rsp_q`.
  - Then go to HOLD with the counter = `HOLD_CYC`-1.
- **HOLD**
  - `ebus_diag_strobe`=0; `ds` and data drives are unchanged.
  - When the counter reaches 0, go to RESP.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle.
  - `rsp_data` = `rsp_q` for reads, 0 for loads. `rsp_data` holds its value until the next RESP.
  - `ebus_ds`=0 and `ebus_data_drive`=0. Next state is IDLE.
- Functions are not interpreted beyond bit 0. 070–077, including 076 (load EBUS register) and 075 (sync), are passed through verbatim.
- `req_func`/`req_data` changes while busy are ignored.
- Reset mid-cycle:
  - Effect: immediate IDLE; the strobe drops asynchronously and no `rsp_valid` is issued for the aborted request.
  - Reset values: `req_ready`=1 once reset deasserts (0 while it is asserted); `rsp_valid`=0; `rsp_data`=0; `busy`=0; `ebus_ds`=0; `ebus_diag_strobe`=0; `ebus_data_out`=0; `ebus_data_drive`=0.

## Timing
- All outputs are registered (glitch-free strobe); none combinationally depends on `req_valid`.
- Accept edge = k. Phase cycles:
  - SETUP: k+1 … k+S.
  - STROBE: k+S+1 … k+S+T.
  - HOLD: k+S+T+1 … k+S+T+H.
  - RESP (`rsp_valid`): cycle k+S+T+H+1.
- Latency from accept to `rsp_valid` is S+T+H+1 cycles; defaults give 6.
- Read data is sampled at the rising edge ending cycle k+S+T, i.e. the last strobe cycle.
- `req_ready` rises in the cycle after RESP. Minimum request spacing is S+T+H+2 cycles.
- `ebus_ds` and the data drive are stable throughout SETUP+STROBE+HOLD.
- No data drive ever occurs during a read function.

## Test plan
- **Reset:** assert `reset` mid-STROBE of a load 071 -> strobe low the same cycle; all outputs at reset values; no `rsp_valid`; next request proceeds normally.
- **Load 076, data 0x0_0000_0F80:**
  - Required: `ebus_ds`=7'o076 and `ebus_data_drive`=1 for 5 cycles; `ebus_diag_strobe` high in cycles 3–4 after accept.
  - Required: `rsp_valid` at cycle 6 with `rsp_data`=0.
- **Read 105, `ebus_data_in`=0x123456789:**
  - Stimulus: change `ebus_data_in` to 0xFFFFFFFFF in the first HOLD cycle.
  - Required: `rsp_data`=0x123456789, `ebus_data_drive` never asserted.
- **Back-to-back:** `req_valid` held high with two requests -> second accepted exactly the cycle after the first RESP; `req_ready` low while busy.
- **Parameter sweep:** SETUP/STROBE/HOLD = 1/1/1 and 15/15/15 -> strobe width 1 and 15 cycles respectively; latency 4 and 46.
- **Request change while busy:** change `req_func`/`req_data` during SETUP -> bus values remain the latched ones.

Source files
------------

// File: rtl/ebus_diag_master.sv
// ebus_diag_master
// Initiator side of the EBOX diagnostic bus. Takes one host request at a time,
// runs the setup / strobe / hold sequence on EBUS and returns a completion
// that carries the captured EBUS word for read functions.
// Bit numbering follows the PDP-10 convention: bit 0 is the most significant.
module ebus_diag_master #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:6]  req_func,
  input  logic [0:35] req_data,
  output logic        rsp_valid,
  output logic [0:35] rsp_data,
  output logic        busy,
  output logic [0:6]  ebus_ds,
  output logic        ebus_diag_strobe,
  output logic [0:35] ebus_data_out,
  output logic        ebus_data_drive,
  input  logic [0:35] ebus_data_in
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

  localparam logic [3:0] SETUP_INIT  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_INIT = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_INIT   = 4'(HOLD_CYC - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_cnt;
  logic [3:0]  w_nextCnt;
  logic        w_accept;

  logic [0:6]  r_func;
  logic [0:35] r_data;
  logic        r_isRead;
  logic [0:35] r_rspQ;

  logic [0:6]  w_funcSel;
  logic [0:35] w_dataSel;
  logic        w_readSel;
  logic        w_nextActive;

  logic        r_rspValid;
  logic [0:35] r_rspData;
  logic        r_busy;
  logic [0:6]  r_ds;
  logic        r_strobe;
  logic [0:35] r_dataOut;
  logic        r_drive;

  // Next-state and phase-counter logic; the counter reloads on every phase entry
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_nextState = SETUP;
          w_nextCnt   = SETUP_INIT;
        end
      end
      SETUP: begin
        if (r_cnt == 4'd0) begin
          w_nextState = STROBE;
          w_nextCnt   = STROBE_INIT;
        end else begin
          w_nextCnt = r_cnt - 4'd1;
        end
      end
      STROBE: begin
        if (r_cnt == 4'd0) begin
          w_nextState = HOLD;
          w_nextCnt   = HOLD_INIT;
        end else begin
          w_nextCnt = r_cnt - 4'd1;
        end
      end
      HOLD: begin
        if (r_cnt == 4'd0) begin
          w_nextState = RESP;
          w_nextCnt   = 4'd0;
        end else begin
          w_nextCnt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        w_nextState = IDLE;
        w_nextCnt   = 4'd0;
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = 4'd0;
      end
    endcase
  end

  // Request fields as they will be after this edge, so bus drives register in step with the state
  always_comb begin
    w_funcSel    = w_accept ? req_func    : r_func;
    w_dataSel    = w_accept ? req_data    : r_data;
    w_readSel    = w_accept ? req_func[0] : r_isRead;
    w_nextActive = (w_nextState == SETUP) || (w_nextState == STROBE) ||
                   (w_nextState == HOLD);
  end

  // State and phase counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Latch the request on accept; later host-side changes are ignored until idle again
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_func   <= '0;
      r_data   <= '0;
      r_isRead <= 1'b0;
    end else if (w_accept) begin
      r_func   <= req_func;
      r_data   <= req_data;
      r_isRead <= req_func[0];
    end
  end

  // Capture the bus word at the edge that ends the last strobe cycle of a read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rspQ <= '0;
    end else if ((r_state == STROBE) && (r_cnt == 4'd0) && r_isRead) begin
      r_rspQ <= ebus_data_in;
    end
  end

  // Registered EBUS and host outputs, decoded from the next state so every output is a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_busy     <= 1'b0;
      r_ds       <= '0;
      r_strobe   <= 1'b0;
      r_dataOut  <= '0;
      r_drive    <= 1'b0;
    end else begin
      r_rspValid <= (w_nextState == RESP);
      r_busy     <= (w_nextState != IDLE);
      r_ds       <= w_nextActive ? w_funcSel : 7'd0;
      r_strobe   <= (w_nextState == STROBE);
      r_drive    <= w_nextActive && !w_readSel;
      r_dataOut  <= (w_nextActive && !w_readSel) ? w_dataSel : 36'd0;
      if (w_nextState == RESP) begin
        r_rspData <= r_isRead ? r_rspQ : 36'd0;
      end
    end
  end

  assign req_ready        = !r_busy && !reset;
  assign rsp_valid        = r_rspValid;
  assign rsp_data         = r_rspData;
  assign busy             = r_busy;
  assign ebus_ds          = r_ds;
  assign ebus_diag_strobe = r_strobe;
  assign ebus_data_out    = r_dataOut;
  assign ebus_data_drive  = r_drive;

endmodule

// File: tb/tb_ebus_diag_master.sv
// tb_ebus_diag_master
// Self-checking bench for ebus_diag_master: a default-parameter instance runs
// the functional scenarios, two extra instances cover the timing extremes.
module tb_ebus_diag_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [0:6]  req_func;
  logic [0:35] req_data;
  logic        rsp_valid;
  logic [0:35] rsp_data;
  logic        busy;
  logic [0:6]  ebus_ds;
  logic        ebus_diag_strobe;
  logic [0:35] ebus_data_out;
  logic        ebus_data_drive;
  logic [0:35] ebus_data_in;

  logic        pValid    [2];
  logic        pReady    [2];
  logic        pRspValid [2];
  logic [0:35] pRspData  [2];
  logic        pBusy     [2];
  logic [0:6]  pDs       [2];
  logic        pStrobe   [2];
  logic [0:35] pDataOut  [2];
  logic        pDrive    [2];
  logic [0:6]  pFunc;
  logic [0:35] pData;

  int          total = 0;
  int          bad   = 0;
  logic [0:35] sb[$];
  logic [0:35] monExp;

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  ebus_diag_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .ebus_ds(ebus_ds),
    .ebus_diag_strobe(ebus_diag_strobe), .ebus_data_out(ebus_data_out),
    .ebus_data_drive(ebus_data_drive), .ebus_data_in(ebus_data_in)
  );

  ebus_diag_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dutFast (
    .clk(clk), .reset(reset), .req_valid(pValid[0]), .req_ready(pReady[0]),
    .req_func(pFunc), .req_data(pData), .rsp_valid(pRspValid[0]),
    .rsp_data(pRspData[0]), .busy(pBusy[0]), .ebus_ds(pDs[0]),
    .ebus_diag_strobe(pStrobe[0]), .ebus_data_out(pDataOut[0]),
    .ebus_data_drive(pDrive[0]), .ebus_data_in(ebus_data_in)
  );

  ebus_diag_master #(.SETUP_CYC(15), .STROBE_CYC(15), .HOLD_CYC(15)) dutSlow (
    .clk(clk), .reset(reset), .req_valid(pValid[1]), .req_ready(pReady[1]),
    .req_func(pFunc), .req_data(pData), .rsp_valid(pRspValid[1]),
    .rsp_data(pRspData[1]), .busy(pBusy[1]), .ebus_ds(pDs[1]),
    .ebus_diag_strobe(pStrobe[1]), .ebus_data_out(pDataOut[1]),
    .ebus_data_drive(pDrive[1]), .ebus_data_in(ebus_data_in)
  );

  // Scoreboard: every completion pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_rsp actual=rsp_valid(data %h) required=no response", rsp_data);
      end else begin
        monExp = sb.pop_front();
        if (rsp_data !== monExp) begin
          bad++;
          $display("[TB] FAIL rsp_data actual=%h required=%h", rsp_data, monExp);
        end
      end
    end
  end

  // Reference model of the default-timing bus (S=2,T=2,H=1) for cycle c after accept:
  // packed as {ds, drive, strobe, rsp_valid, busy, req_ready, data_out}
  function automatic logic [47:0] expBus(input int c, input logic [0:6] f,
                                         input logic [0:35] d, input logic rd);
    logic        inPhase;
    logic        drv;
    logic        bsy;
    logic [0:6]  ds;
    logic [0:35] dout;
    inPhase = (c >= 1) && (c <= 5);
    drv     = inPhase && !rd;
    bsy     = (c >= 1) && (c <= 6);
    ds      = inPhase ? f : 7'd0;
    dout    = drv ? d : 36'd0;
    return {ds, drv, (c == 3 || c == 4), (c == 6), bsy, !bsy, dout};
  endfunction

  // Present one request at a falling edge, queue its expected completion, and
  // return at the falling edge of the first cycle after the accept edge
  task automatic sendReq(input logic [0:6] f, input logic [0:35] d, input logic [0:35] e);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL send_ready actual=%b required=1", req_ready);
    end else begin
      req_valid = 1'b1;
      req_func  = f;
      req_data  = d;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // Wait, with a cycle budget, until all queued completions have been seen
  task automatic waitDone(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_timeout actual=%0d pending required=0 pending", name, sb.size());
    end
  endtask

  task automatic test_reset();
    logic [0:6]  outsA;
    logic [0:35] zero36;
    zero36 = '0;
    reset = 1'b1;
    @(negedge clk);
    outsA = {req_ready, rsp_valid, busy, ebus_diag_strobe, ebus_data_drive, 2'b00};
    total++;
    if (outsA !== 7'd0 || ebus_ds !== 7'd0 || ebus_data_out !== zero36 || rsp_data !== zero36) begin
      bad++;
      $display("[TB] FAIL reset_held actual=%b/%o/%h/%h required=0", outsA, ebus_ds, ebus_data_out, rsp_data);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release actual=ready%b busy%b required=ready1 busy0", req_ready, busy);
    end
    sendReq(7'o071, 36'h0F0F0F0F0, 36'h0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (ebus_diag_strobe !== 1'b1 || ebus_ds !== 7'o071) begin
      bad++;
      $display("[TB] FAIL abort_prestrobe actual=%b/%o required=1/071", ebus_diag_strobe, ebus_ds);
    end
    #1 reset = 1'b1;
    #1;
    outsA = {req_ready, rsp_valid, busy, ebus_diag_strobe, ebus_data_drive, 2'b00};
    total++;
    if (outsA !== 7'd0 || ebus_ds !== 7'd0 || ebus_data_out !== zero36 || rsp_data !== zero36) begin
      bad++;
      $display("[TB] FAIL abort_async actual=%b/%o/%h/%h required=0", outsA, ebus_ds, ebus_data_out, rsp_data);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_idle actual=ready%b busy%b required=ready1 busy0", req_ready, busy);
    end
  endtask

  task automatic test_load076();
    logic [47:0] got;
    logic [47:0] exp;
    sendReq(7'o076, 36'h000000F80, 36'h0);
    for (int c = 1; c <= 7; c++) begin
      got = {ebus_ds, ebus_data_drive, ebus_diag_strobe, rsp_valid, busy, req_ready, ebus_data_out};
      exp = expBus(c, 7'o076, 36'h000000F80, 1'b0);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL load076_c%0d actual=%h required=%h", c, got, exp);
      end
      if (c < 7) @(negedge clk);
    end
    waitDone("load076");
  endtask

  task automatic test_read105();
    logic [47:0] got;
    logic [47:0] exp;
    ebus_data_in = 36'h123456789;
    sendReq(7'o105, 36'h0ABCDEF01, 36'h123456789);
    for (int c = 1; c <= 7; c++) begin
      got = {ebus_ds, ebus_data_drive, ebus_diag_strobe, rsp_valid, busy, req_ready, ebus_data_out};
      exp = expBus(c, 7'o105, 36'h0ABCDEF01, 1'b1);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL read105_c%0d actual=%h required=%h", c, got, exp);
      end
      if (c == 5) ebus_data_in = 36'hFFFFFFFFF;
      if (c == 7) begin
        total++;
        if (rsp_data !== 36'h123456789) begin
          bad++;
          $display("[TB] FAIL read105_hold actual=%h required=%h", rsp_data, 36'h123456789);
        end
      end
      if (c < 7) @(negedge clk);
    end
    waitDone("read105");
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    logic [7:0] exp;
    @(negedge clk);
    req_valid = 1'b1;
    req_func  = 7'o072;
    req_data  = 36'h111111111;
    sb.push_back(36'h0);
    @(negedge clk);
    req_func     = 7'o117;
    req_data     = 36'h222222222;
    ebus_data_in = 36'h0DEADBEEF;
    sb.push_back(36'h0DEADBEEF);
    for (int c = 1; c <= 7; c++) begin
      got = {req_ready, ebus_ds};
      exp = {(c == 7), (c <= 5) ? 7'o072 : 7'o000};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL b2b_c%0d actual=%h required=%h", c, got, exp);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || ebus_ds !== 7'o117 || ebus_data_drive !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_second actual=busy%b ds%o drv%b required=busy1 ds117 drv0", busy, ebus_ds, ebus_data_drive);
    end
    waitDone("b2b");
  endtask

  task automatic test_busy_change();
    logic [47:0] got;
    logic [47:0] exp;
    sendReq(7'o074, 36'h555555555, 36'h0);
    for (int c = 1; c <= 7; c++) begin
      got = {ebus_ds, ebus_data_drive, ebus_diag_strobe, rsp_valid, busy, req_ready, ebus_data_out};
      exp = expBus(c, 7'o074, 36'h555555555, 1'b0);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL busychg_c%0d actual=%h required=%h", c, got, exp);
      end
      if (c == 1) begin
        req_func = 7'o033;
        req_data = 36'hAAAAAAAAA;
      end
      if (c < 7) @(negedge clk);
    end
    waitDone("busychg");
  endtask

  task automatic test_param_sweep();
    int   sw;
    int   lat;
    int   expW;
    int   expL;
    logic seen;
    pFunc = 7'o071;
    pData = 36'h0C0FFEE00;
    for (int i = 0; i < 2; i++) begin
      sw   = 0;
      lat  = 0;
      seen = 1'b0;
      expW = (i == 0) ? 1 : 15;
      expL = (i == 0) ? 4 : 46;
      @(negedge clk);
      total++;
      if (pReady[i] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL sweep%0d_ready actual=%b required=1", i, pReady[i]);
      end
      pValid[i] = 1'b1;
      @(negedge clk);
      pValid[i] = 1'b0;
      for (int n = 1; n <= 100 && !seen; n++) begin
        if (pStrobe[i] === 1'b1) sw++;
        if (pRspValid[i] === 1'b1) begin
          seen = 1'b1;
          lat  = n;
        end else begin
          @(negedge clk);
        end
      end
      total++;
      if (!seen || lat != expL) begin
        bad++;
        $display("[TB] FAIL sweep%0d_latency actual=%0d seen=%b required=%0d", i, lat, seen, expL);
      end
      total++;
      if (sw != expW) begin
        bad++;
        $display("[TB] FAIL sweep%0d_strobe_width actual=%0d required=%0d", i, sw, expW);
      end
      total++;
      if (pRspData[i] !== 36'h0) begin
        bad++;
        $display("[TB] FAIL sweep%0d_rsp_data actual=%h required=0", i, pRspData[i]);
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_func     = '0;
    req_data     = '0;
    ebus_data_in = '0;
    pValid[0]    = 1'b0;
    pValid[1]    = 1'b0;
    pFunc        = '0;
    pData        = '0;
    test_reset();
    test_load076();
    test_read105();
    test_back_to_back();
    test_busy_change();
    test_param_sweep();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
